pad_mux_ctrl: RTL and testbench

PAD_MUX_CTRL -- requirements
Module: pad_mux_ctrl

---
 rtl/pad_mux_pkg.sv | 25 ++
 rtl/pad_sync.sv | 27 ++
 rtl/pad_mux_ctrl.sv | 156 +++++++++++++++
 tb/tb_pad_mux_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_mux_pkg.sv
// Shared definitions for the pad multiplexer: FSM states, register map and field offsets.
package pad_mux_pkg;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_RUN    = 2'd2
  } pad_state_t;

  localparam logic [7:0] CTRL_ADDR = 8'hFF;
  localparam int CTRL_LOCK_BIT  = 0;
  localparam int CTRL_STATE_LSB = 1;
  localparam int CTRL_BOOT_BIT  = 3;

  // PADCFG fields sit directly above FSEL, so they are offsets from the FSEL width.
  localparam int PADCFG_OUT_INV_OFS    = 0;
  localparam int PADCFG_IN_INV_OFS     = 1;
  localparam int PADCFG_OE_OVR_EN_OFS  = 2;
  localparam int PADCFG_OE_OVR_VAL_OFS = 3;

  function automatic int fsel_width(input int num_funcs);
    return (num_funcs > 1) ? $clog2(num_funcs) : 1;
  endfunction

endpackage

// File: rtl/pad_sync.sv
// Per-bit multi-flop synchroniser with asynchronous active-low reset.
module pad_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // Fewer than two flops is not a synchroniser, so the depth is clamped.
  localparam int DEPTH = (STAGES < 2) ? 2 : STAGES;

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < DEPTH; s++) stage_q[s] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int s = 1; s < DEPTH; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/pad_mux_ctrl.sv
// Pad multiplexer: per-pad function select, inversion and OE override behind a Wishbone
// register file, with a strap sequencer that keeps the pads tristated until boot mode is known.
module pad_mux_ctrl
  import pad_mux_pkg::*;
#(
  parameter int NUM_PADS    = 44,
  parameter int NUM_FUNCS   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STRAP_DELAY = 16,
  parameter int STRAP_PAD   = 10
) (
  input  logic                          wb_clk_i,
  input  logic                          porb_l,
  input  logic                          wb_cyc_i,
  input  logic                          wb_stb_i,
  input  logic                          wb_we_i,
  input  logic [7:0]                    wb_adr_i,
  input  logic [3:0]                    wb_sel_i,
  input  logic [31:0]                   wb_dat_i,
  output logic [31:0]                   wb_dat_o,
  output logic                          wb_ack_o,
  input  logic [NUM_PADS*NUM_FUNCS-1:0] func_out,
  input  logic [NUM_PADS*NUM_FUNCS-1:0] func_oe,
  output logic [NUM_PADS-1:0]           func_in,
  input  logic [NUM_PADS-1:0]           pad_in,
  output logic [NUM_PADS-1:0]           pad_out,
  output logic [NUM_PADS-1:0]           pad_oeb,
  output logic                          boot_mode
);
  localparam int FW    = fsel_width(NUM_FUNCS);
  localparam int CW    = FW + 4;
  localparam int CNT_W = $clog2(STRAP_DELAY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STRAP_DELAY - 1);
  localparam logic [8:0]       PAD_LIMIT  = 9'(NUM_PADS);
  localparam logic [FW:0]      FUNC_LIMIT = (FW+1)'(NUM_FUNCS);

  pad_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CW-1:0]       cfg_q [NUM_PADS];
  logic                lock_q, boot_q, ack_q;
  logic [31:0]         dat_q, rd_data, be_mask, merged;
  logic [CW-1:0]       pad_rd;
  logic [NUM_PADS-1:0] sync_q, out_mux, oeb_mux, pad_out_q, pad_oeb_q;
  logic                wb_req, wb_wr, adr_is_pad, cfg_wr_en, lock_set;
  logic                unused_merged;

  pad_sync #(.WIDTH(NUM_PADS), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (wb_clk_i),
    .rst_n (porb_l),
    .d     (pad_in),
    .q     (sync_q)
  );

  assign wb_req     = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wb_wr      = wb_req & wb_we_i;
  assign adr_is_pad = ({1'b0, wb_adr_i} < PAD_LIMIT);
  assign be_mask    = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign merged     = ({{(32-CW){1'b0}}, pad_rd} & ~be_mask) | (wb_dat_i & be_mask);
  assign cfg_wr_en  = wb_wr & adr_is_pad & (state_q == ST_RUN) & ~lock_q;
  assign lock_set   = wb_wr & (wb_adr_i == CTRL_ADDR) & wb_sel_i[0] & wb_dat_i[CTRL_LOCK_BIT];
  assign unused_merged = ^merged[31:CW];

  always_comb begin
    pad_rd = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      if (wb_adr_i == 8'(i)) pad_rd = cfg_q[i];
    end
  end

  always_comb begin
    rd_data = '0;
    if (wb_adr_i == CTRL_ADDR) begin
      rd_data[CTRL_LOCK_BIT]         = lock_q;
      rd_data[CTRL_STATE_LSB +: 2]   = state_q;
      rd_data[CTRL_BOOT_BIT]         = boot_q;
    end else begin
      rd_data[CW-1:0] = pad_rd;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT:   if (cnt_q == CNT_LAST) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = ST_RUN;
      ST_RUN:    state_d = ST_RUN;
      default:   state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge porb_l) begin
    if (!porb_l) begin
      state_q <= ST_WAIT;
      cnt_q   <= '0;
      lock_q  <= 1'b0;
      boot_q  <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_WAIT) cnt_q <= cnt_q + 1'b1;
      if (state_q == ST_SAMPLE) boot_q <= sync_q[STRAP_PAD];
      if (lock_set) lock_q <= 1'b1;
      ack_q <= wb_req;
      if (wb_req) dat_q <= rd_data;
    end
  end

  // A strapped boot forces every pad onto function 1 before software gets access.
  always_ff @(posedge wb_clk_i or negedge porb_l) begin
    if (!porb_l) begin
      for (int i = 0; i < NUM_PADS; i++) cfg_q[i] <= '0;
    end else if (state_q == ST_SAMPLE) begin
      if (sync_q[STRAP_PAD]) begin
        for (int i = 0; i < NUM_PADS; i++) cfg_q[i][FW-1:0] <= FW'(1);
      end
    end else if (cfg_wr_en) begin
      for (int i = 0; i < NUM_PADS; i++) begin
        if (wb_adr_i == 8'(i)) cfg_q[i] <= merged[CW-1:0];
      end
    end
  end

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
    logic [NUM_FUNCS-1:0] fo, fe;
    logic [FW-1:0]        fs;
    assign fo = func_out[g*NUM_FUNCS +: NUM_FUNCS];
    assign fe = func_oe[g*NUM_FUNCS +: NUM_FUNCS];
    assign fs = ({1'b0, cfg_q[g][FW-1:0]} < FUNC_LIMIT) ? cfg_q[g][FW-1:0] : '0;
    assign out_mux[g] = fo[fs] ^ cfg_q[g][FW+PADCFG_OUT_INV_OFS];
    assign oeb_mux[g] = cfg_q[g][FW+PADCFG_OE_OVR_EN_OFS] ? cfg_q[g][FW+PADCFG_OE_OVR_VAL_OFS]
                                                          : ~fe[fs];
    assign func_in[g] = sync_q[g] ^ cfg_q[g][FW+PADCFG_IN_INV_OFS];
  end

  // Registering the mux output hides any select/data skew from the pads.
  always_ff @(posedge wb_clk_i or negedge porb_l) begin
    if (!porb_l) begin
      pad_out_q <= '0;
      pad_oeb_q <= '1;
    end else if (state_q == ST_RUN) begin
      pad_out_q <= out_mux;
      pad_oeb_q <= oeb_mux;
    end else begin
      pad_out_q <= '0;
      pad_oeb_q <= '1;
    end
  end

  assign pad_out   = pad_out_q;
  assign pad_oeb   = pad_oeb_q;
  assign wb_ack_o  = ack_q;
  assign wb_dat_o  = dat_q;
  assign boot_mode = boot_q;

endmodule

// File: tb/tb_pad_mux_ctrl.sv
// Self-checking bench for pad_mux_ctrl: randomized traffic against a time-based reference model
// plus directed strap, lock, override and inversion scenarios with literal expectations.
module tb_pad_mux_ctrl;
  localparam int NP = 44;
  localparam int NF = 4;
  localparam int SS = 2;
  localparam int SD = 16;
  localparam int SP = 10;
  localparam logic [NP-1:0] ALL1 = '1;

  logic             clk, porb_l;
  logic             cyc, stb, we, ack;
  logic [7:0]       adr;
  logic [3:0]       sel;
  logic [31:0]      dat_i, dat_o;
  logic [NP*NF-1:0] func_out, func_oe;
  logic [NP-1:0]    func_in, pad_in, pad_out, pad_oeb;
  logic             boot_mode;

  int checks = 0;
  int errors = 0;

  pad_mux_ctrl #(
    .NUM_PADS(NP), .NUM_FUNCS(NF), .SYNC_STAGES(SS), .STRAP_DELAY(SD), .STRAP_PAD(SP)
  ) dut (
    .wb_clk_i(clk), .porb_l(porb_l),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_i), .wb_dat_o(dat_o), .wb_ack_o(ack),
    .func_out(func_out), .func_oe(func_oe), .func_in(func_in),
    .pad_in(pad_in), .pad_out(pad_out), .pad_oeb(pad_oeb), .boot_mode(boot_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: state is derived from the number of clock edges since reset release.
  int            since_rst;
  int            cfg_m [NP];
  bit            lock_m, boot_m, exp_ack, m_req;
  logic [NP-1:0] exp_pad_out, exp_oeb, exp_func_in, m_synced;
  logic [31:0]   exp_dat;
  logic [NP-1:0] in_hist[$];
  int            m_phase, m_fs;

  always @(posedge clk or negedge porb_l) begin
    if (!porb_l) begin
      since_rst = 0;
      for (int i = 0; i < NP; i++) cfg_m[i] = 0;
      lock_m = 0; boot_m = 0; exp_ack = 0; exp_dat = '0;
      exp_pad_out = '0; exp_oeb = '1; exp_func_in = '0;
      in_hist.delete();
    end else begin
      m_phase  = (since_rst < SD) ? 0 : ((since_rst == SD) ? 1 : 2);
      m_synced = (in_hist.size() >= SS) ? in_hist[SS-1] : '0;
      for (int i = 0; i < NP; i++) begin
        m_fs = cfg_m[i] % 4;
        if (m_fs >= NF) m_fs = 0;
        if (m_phase == 2) begin
          exp_pad_out[i] = func_out[i*NF+m_fs] ^ 1'((cfg_m[i] >> 2) & 1);
          exp_oeb[i] = (((cfg_m[i] >> 4) & 1) == 1) ? 1'((cfg_m[i] >> 5) & 1)
                                                     : !func_oe[i*NF+m_fs];
        end else begin
          exp_pad_out[i] = 1'b0;
          exp_oeb[i]     = 1'b1;
        end
      end
      m_req = cyc && stb && !exp_ack;
      if (m_req) begin
        if (adr == 8'hFF) exp_dat = 32'(boot_m) * 8 + 32'(m_phase) * 2 + 32'(lock_m);
        else if (int'(adr) < NP) exp_dat = 32'(cfg_m[int'(adr)]);
        else exp_dat = '0;
        if (we) begin
          if (int'(adr) < NP && m_phase == 2 && !lock_m && sel[0])
            cfg_m[int'(adr)] = int'(dat_i[5:0]);
          if (adr == 8'hFF && sel[0] && dat_i[0]) lock_m = 1;
        end
      end
      exp_ack = m_req;
      if (m_phase == 1) begin
        boot_m = m_synced[SP];
        if (boot_m) for (int i = 0; i < NP; i++) cfg_m[i] = (cfg_m[i] / 4) * 4 + 1;
      end
      in_hist.push_front(pad_in);
      if (in_hist.size() > SS) void'(in_hist.pop_back());
      m_synced = (in_hist.size() >= SS) ? in_hist[SS-1] : '0;
      for (int i = 0; i < NP; i++) exp_func_in[i] = m_synced[i] ^ 1'((cfg_m[i] >> 3) & 1);
      if (since_rst < 100000) since_rst++;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (porb_l === 1'b1) begin
      checkOutput("pad_out", 64'(pad_out), 64'(exp_pad_out));
      checkOutput("pad_oeb", 64'(pad_oeb), 64'(exp_oeb));
      checkOutput("func_in", 64'(func_in), 64'(exp_func_in));
      checkOutput("wb_ack", 64'(ack), 64'(exp_ack));
      checkOutput("boot_mode", 64'(boot_mode), 64'(boot_m));
      if (exp_ack) checkOutput("wb_dat", 64'(dat_o), 64'(exp_dat));
    end
  end

  task automatic applyStimulus(input bit wr, input logic [7:0] a, input logic [3:0] s,
                               input logic [31:0] d, output logic [31:0] rd);
    int n;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = wr; adr = a; sel = s; dat_i = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 8);
    checks++;
    if (!ack) begin
      errors++;
      $display("[TB] FAIL wb_ack_timeout: got no ack, expected ack within 8 cycles (adr %h)", a);
    end
    rd  = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  function automatic logic [191:0] rand192();
    logic [191:0] r;
    for (int w = 0; w < 6; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  logic [191:0] tmp;
  logic [31:0]  rd;
  int           kind;

  initial begin
    porb_l = 1'b0; cyc = 0; stb = 0; we = 0; adr = '0; sel = '0; dat_i = '0;
    tmp = rand192(); func_out = tmp[NP*NF-1:0];
    tmp = rand192(); func_oe  = tmp[NP*NF-1:0];
    tmp = rand192(); pad_in   = tmp[NP-1:0];
    pad_in[SP] = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_pad_oeb", 64'(pad_oeb), 64'(ALL1));
    checkOutput("rst_pad_out", 64'(pad_out), 64'd0);
    checkOutput("rst_ack", 64'(ack), 64'd0);
    checkOutput("rst_dat", 64'(dat_o), 64'd0);
    checkOutput("rst_boot", 64'(boot_mode), 64'd0);
    porb_l = 1'b1;
    for (int c = 0; c < SD + 1; c++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("gated_oeb", 64'(pad_oeb), 64'(ALL1));
    end
    applyStimulus(0, 8'hFF, 4'hF, 32'h0, rd);
    checkOutput("ctrl_run_boot0", 64'(rd), 64'h4);
    applyStimulus(0, 8'd5, 4'hF, 32'h0, rd);
    checkOutput("fsel_default", 64'(rd), 64'h0);

    func_out = '0; func_out[14] = 1'b1; pad_in = '0;
    applyStimulus(1, 8'd3, 4'hF, 32'h06, rd);
    @(posedge clk); @(negedge clk);
    checkOutput("pad3_inv_fsel2", 64'(pad_out[3]), 64'd0);
    applyStimulus(0, 8'd3, 4'hF, 32'h0, rd);
    checkOutput("padcfg3_rb", 64'(rd), 64'h06);

    func_oe = '0; func_oe[28] = 1'b1;
    applyStimulus(1, 8'd7, 4'hF, 32'h30, rd);
    @(posedge clk); @(negedge clk);
    checkOutput("pad7_oe_ovr", 64'(pad_oeb[7]), 64'd1);
    applyStimulus(0, 8'h80, 4'hF, 32'h0, rd);
    checkOutput("unmapped_rd", 64'(rd), 64'h0);

    applyStimulus(1, 8'd2, 4'hF, 32'h08, rd);
    checkOutput("func_in2_inv_idle", 64'(func_in[2]), 64'd1);
    pad_in[2] = 1'b1;
    @(posedge clk); @(negedge clk);
    checkOutput("func_in2_1cyc", 64'(func_in[2]), 64'd1);
    @(posedge clk); @(negedge clk);
    checkOutput("func_in2_2cyc", 64'(func_in[2]), 64'd0);

    repeat (300) begin
      tmp = rand192(); func_out = tmp[NP*NF-1:0];
      tmp = rand192(); func_oe  = tmp[NP*NF-1:0];
      tmp = rand192(); pad_in   = tmp[NP-1:0];
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2, 3: applyStimulus(1, 8'($urandom_range(0, NP-1)), 4'($urandom), $urandom, rd);
        4, 5:       applyStimulus(0, 8'($urandom_range(0, NP-1)), 4'hF, 32'h0, rd);
        6:          applyStimulus(0, 8'($urandom_range(NP, 254)), 4'hF, 32'h0, rd);
        7:          applyStimulus(0, 8'hFF, 4'hF, 32'h0, rd);
        8:          applyStimulus(1, 8'($urandom_range(NP, 254)), 4'hF, $urandom, rd);
        default:    @(negedge clk);
      endcase
    end

    applyStimulus(1, 8'd0, 4'hF, 32'h0, rd);
    applyStimulus(1, 8'hFF, 4'hF, 32'h1, rd);
    applyStimulus(1, 8'd0, 4'hF, 32'h3, rd);
    applyStimulus(0, 8'd0, 4'hF, 32'h0, rd);
    checkOutput("locked_write", 64'(rd), 64'h0);
    applyStimulus(1, 8'hFF, 4'hF, 32'h0, rd);
    applyStimulus(0, 8'hFF, 4'hF, 32'h0, rd);
    checkOutput("lock_sticky", 64'(rd), 64'h5);

    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'd9; sel = 4'hF; dat_i = 32'h3C;
    @(posedge clk);
    #2 porb_l = 1'b0;
    #1 checkOutput("rst_drops_ack", 64'(ack), 64'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    pad_in = '0; pad_in[SP] = 1'b1; func_out = '0; func_oe = '0;
    repeat (3) @(negedge clk);
    porb_l = 1'b1;
    repeat (SD + 1) begin
      @(posedge clk);
      @(negedge clk);
    end
    applyStimulus(0, 8'hFF, 4'hF, 32'h0, rd);
    checkOutput("ctrl_run_boot1", 64'(rd), 64'hC);
    applyStimulus(0, 8'd5, 4'hF, 32'h0, rd);
    checkOutput("padcfg5_strap", 64'(rd), 64'h1);
    applyStimulus(0, 8'd9, 4'hF, 32'h0, rd);
    checkOutput("padcfg9_no_partial", 64'(rd), 64'h1);
    func_out[21] = 1'b1; func_oe[21] = 1'b1;
    @(posedge clk); @(negedge clk);
    checkOutput("pad5_func1_hi", 64'(pad_out[5]), 64'd1);
    checkOutput("pad5_oe_on", 64'(pad_oeb[5]), 64'd0);
    func_out[21] = 1'b0; func_out[20] = 1'b1;
    @(posedge clk); @(negedge clk);
    checkOutput("pad5_func1_lo", 64'(pad_out[5]), 64'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
